priority_irq_ctrl: RTL and testbench
====================================

# priority_irq_ctrl

Parametrised, registered priority interrupt controller: the next-generation N-input priority encoder.
- Latches active-low request lines into a pending register and applies a per-line mask.
- Presents the highest-priority unmasked index through a valid/acknowledge handshake.
- Keeps the active-low enable-in/enable-out cascade so several controllers can be chained into a wider priority chain.

## Interface
Parameters:
- N, 8, number of request lines (N >= 2); bit N-1 is highest priority.
- W, $clog2(N), index width (derived localparam, not overridable).

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst_n  in  1  reset, synchronous, active-low.
- iReq_n  in  N  request lines, active-low (0 = requesting).
- iMask  in  N  per-line mask, 1 = line may pend but is never granted.
- iEI  in  1  cascade enable-in, active-low (0 = this stage may grant).
- iAck  in  1  consumer acknowledge of the current grant.
- oIdx  out  W  granted index, registered.
- oValid  out  1  grant valid, registered.
- oEO  out  1  cascade enable-out, active-low; 0 when iEI=0, no unmasked pending bit, and oValid=0.
- oPend  out  N  pending register contents, registered.

## Operation
- Pending register P: set term S[i], clear term C[i].
  - Level mode: S[i] = ~iReq_n[i].
  - C[i] = 1 only for i = oIdx when oValid & iAck.
  - Next P[i] = S[i] | (P[i] & ~C[i]); set wins over clear in the same cycle.
- Eligible vector E = P & ~iMask; any = |E.
- Priority select: highest i with E[i]=1.
- State machine, two states:
  - IDLE: oValid=0. If iEI=0 and any=1, load oIdx with the priority select and go to GRANT.
  - GRANT: oValid=1 and oIdx held stable. If iAck=1, clear P[oIdx] and return to IDLE. Otherwise stay.
- No retraction. Once in GRANT, the grant holds until iAck, regardless of:
  - iEI rising;
  - iMask changes;
  - a higher-priority request arriving.
- iAck while oValid=0 is ignored.
- oEO is combinational from iEI, E and oValid (no added register).
  - Cascade: oEO of a higher stage drives iEI of the next lower stage.
- Reset (iRst_n=0 at a rising edge), including mid-grant:
  - P=0, oValid=0, oIdx=0, state IDLE, edge history = all 1s.
  - Any in-flight grant is dropped without a clear.

## Timing
- Request-to-grant latency: 2 cycles.
  - iReq_n[i] low before edge k → P[i]=1 after edge k → oValid=1, oIdx=i after edge k+1 (assuming iEI=0, unmasked, IDLE).
- Acknowledge: iAck=1 at edge k → oValid=0 and P[oIdx] cleared after edge k (unless re-set).
  - Next grant at edge k+1 at the earliest.
  - Maximum throughput: one grant per 2 cycles.
- oIdx is stable for the whole time oValid=1.
- After reset release, the first grant comes 2 edges after the first sampled request.

## Configuration
- IRQ_EDGE_EN defined: edge-triggered capture.
  - History register H samples iReq_n each cycle; S[i] = H[i] & ~iReq_n[i] (falling edge only).
  - A line held low sets P once; re-pend needs a release and a new falling edge.
  - H resets to all 1s, so a line low at reset release pends on the first cycle.
- IRQ_EDGE_EN undefined: level mode as above.
  - An acknowledged line still held low re-pends on the same edge.
  - No H register is built.

## Test plan
- Reset/priority (N=8, level): iRst_n=0 for 2 cycles, then iEI=0, iMask=0, iReq_n=8'b0110_1111.
  - Required: after 2 edges, oValid=1, oIdx=7.
  - During reset: oPend=0, oValid=0, oEO=0.
- Ack sequencing (level): same requests, release each line on its grant; ack each grant.
  - Required: grants 7 then 4, each oIdx held until iAck.
  - Then oValid=0, oPend=0, oEO=0.
- Mask/enable: iMask=8'h80, iReq_n=8'h7F → P[7]=1, no grant, oEO=0.
  - Clear mask → grant 7.
  - With iEI=1: no grant and oEO=1.
- No retraction: grant idx 2 active, then assert iReq_n[6]=0 and iEI=1.
  - Required: oIdx stays 2 until iAck.
  - On iAck: P[2] cleared. With iEI back to 0, next grant is 6.
- Set-wins and reset mid-grant (level): hold iReq_n[3]=0 through iAck.
  - Required: P[3] stays 1, grant 3 reissued 1 cycle later.
  - iRst_n=0 during GRANT → oValid=0, oPend=0 next edge.
- Edge mode (IRQ_EDGE_EN): hold iReq_n[5]=0 for 10 cycles, ack the first grant.
  - Required: exactly one grant of 5.
  - Releasing and re-lowering the line produces a second grant of 5.

Source files
------------

// File: rtl/priority_irq_ctrl.sv
// priority_irq_ctrl: registered N-line priority interrupt controller.
// Active-low requests are latched into a pending register and masked per line.
// The highest-priority eligible line is granted through oValid/iAck.
// An active-low enable-in/enable-out pair lets controllers be cascaded.
//
// Ports:
//   iClk    clock, rising edge
//   iRst_n  synchronous active-low reset
//   iReq_n  [N] request lines, 0 = requesting
//   iMask   [N] 1 = line may pend but is never granted
//   iEI     cascade enable-in, 0 = this stage may grant
//   iAck    consumer acknowledge of the current grant
//   oIdx    [W] granted index, held while oValid=1
//   oValid  grant valid
//   oEO     cascade enable-out, 0 = enabled, idle and nothing eligible
//   oPend   [N] pending register contents
//
// Build option: define IRQ_EDGE_EN for falling-edge capture of requests;
// otherwise requests are captured by level.

module priority_irq_ctrl #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [N-1:0] iReq_n,
    input  logic [N-1:0] iMask,
    input  logic         iEI,
    input  logic         iAck,
    output logic [W-1:0] oIdx,
    output logic         oValid,
    output logic         oEO,
    output logic [N-1:0] oPend
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t       state;
    logic [N-1:0] pend;
    logic [N-1:0] setV;
    logic [N-1:0] clrV;
    logic [N-1:0] elig;
    logic         any;
    logic [W-1:0] selIdx;

`ifdef IRQ_EDGE_EN
    logic [N-1:0] hist;

    // Previous sample of the request lines; all 1s after reset so a line
    // already low when reset is released is seen as a fresh falling edge.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            hist <= '1;
        end else begin
            hist <= iReq_n;
        end
    end

    assign setV = hist & ~iReq_n;
`else
    assign setV = ~iReq_n;
`endif

    // Only the line currently being acknowledged is cleared.
    always_comb begin
        clrV = '0;
        for (int i = 0; i < N; i++) begin
            clrV[i] = oValid & iAck & (oIdx == W'(i));
        end
    end

    assign elig = pend & ~iMask;
    assign any  = |elig;

    // Ascending scan: the last hit is the highest eligible index.
    always_comb begin
        selIdx = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                selIdx = W'(i);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state  <= IDLE;
            oValid <= 1'b0;
            oIdx   <= '0;
            pend   <= '0;
        end else begin
            // A set in the same cycle as a clear keeps the line pending.
            pend <= setV | (pend & ~clrV);
            unique case (state)
                IDLE: begin
                    if (!iEI && any) begin
                        oIdx   <= selIdx;
                        oValid <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    // No retraction: only iAck ends a grant.
                    if (iAck) begin
                        oValid <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    // Low only when enabled, idle and with nothing eligible, so the next
    // lower stage in the chain may grant.
    assign oEO   = iEI | any | oValid;
    assign oPend = pend;

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// tb_priority_irq_ctrl: vector table plus grant scoreboard for
// priority_irq_ctrl with N=8.

module tb_priority_irq_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         iRst_n;
    logic [N-1:0] iReq_n;
    logic [N-1:0] iMask;
    logic         iEI;
    logic         iAck;
    logic [2:0]   oIdx;
    logic         oValid;
    logic         oEO;
    logic [N-1:0] oPend;

    int checks;
    int failures;

    typedef struct {
        logic       rstN;
        logic [7:0] reqN;
        logic [7:0] mask;
        logic       ei;
        logic       ack;
        logic       expValid;
        logic [2:0] expIdx;
        logic       expEO;
        logic [7:0] expPend;
    } vec_t;

    vec_t       vecs[$];
    vec_t       expQ[$];
    logic [2:0] grantQ[$];

    priority_irq_ctrl #(.N(N)) dut (
        .iClk   (clk),
        .iRst_n (iRst_n),
        .iReq_n (iReq_n),
        .iMask  (iMask),
        .iEI    (iEI),
        .iAck   (iAck),
        .oIdx   (oIdx),
        .oValid (oValid),
        .oEO    (oEO),
        .oPend  (oPend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic r, logic [7:0] q, logic [7:0] m, logic e,
                       logic a, logic v, logic [2:0] x, logic o,
                       logic [7:0] p);
        vec_t t;
        t.rstN = r; t.reqN = q; t.mask = m; t.ei = e; t.ack = a;
        t.expValid = v; t.expIdx = x; t.expEO = o; t.expPend = p;
        vecs.push_back(t);
    endtask

    task automatic runRow(vec_t v, int row);
        vec_t e;
        iRst_n = v.rstN;
        iReq_n = v.reqN;
        iMask  = v.mask;
        iEI    = v.ei;
        iAck   = v.ack;
        expQ.push_back(v);
        tick();
        e = expQ.pop_front();
        chk($sformatf("row%0d_valid", row), int'(oValid), int'(e.expValid));
        if (e.expValid)
            chk($sformatf("row%0d_idx", row), int'(oIdx), int'(e.expIdx));
        chk($sformatf("row%0d_eo", row), int'(oEO), int'(e.expEO));
        chk($sformatf("row%0d_pend", row), int'(oPend), int'(e.expPend));
    endtask

    // Every completed handshake must match the next expected grant.
    always @(negedge clk) begin
        if (iRst_n === 1'b1 && oValid === 1'b1 && iAck === 1'b1) begin
            if (grantQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL grant_extra: got idx %0d, want no grant",
                         oIdx);
            end else begin
                chk("grant_idx", int'(oIdx), int'(grantQ.pop_front()));
            end
        end
    end

    initial begin
        int nGrant;
        bit found;
        checks   = 0;
        failures = 0;
        iRst_n = 1'b0;
        iReq_n = '1;
        iMask  = '0;
        iEI    = 1'b0;
        iAck   = 1'b0;

        //   rst req    mask   ei ack  val idx eo pend
        add(0, 8'hFF, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(0, 8'hFF, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'h6F, 8'h00, 0, 0,  0, 0, 1, 8'h90);
        add(1, 8'h6F, 8'h00, 0, 0,  1, 7, 1, 8'h90);
        add(1, 8'h6F, 8'h00, 0, 0,  1, 7, 1, 8'h90);
        add(1, 8'hEF, 8'h00, 0, 1,  0, 0, 1, 8'h10);
        add(1, 8'hEF, 8'h00, 0, 0,  1, 4, 1, 8'h10);
        add(1, 8'hEF, 8'h00, 0, 0,  1, 4, 1, 8'h10);
        add(1, 8'hFF, 8'h00, 0, 1,  0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'h7F, 8'h80, 0, 0,  0, 0, 0, 8'h80);
        add(1, 8'h7F, 8'h80, 0, 0,  0, 0, 0, 8'h80);
        add(1, 8'h7F, 8'h00, 0, 0,  1, 7, 1, 8'h80);
        add(1, 8'hFF, 8'h00, 0, 1,  0, 0, 0, 8'h00);
        add(1, 8'h7F, 8'h00, 1, 0,  0, 0, 1, 8'h80);
        add(1, 8'h7F, 8'h00, 1, 0,  0, 0, 1, 8'h80);
        add(1, 8'hFF, 8'h00, 0, 0,  1, 7, 1, 8'h80);
        add(1, 8'hFF, 8'h00, 0, 1,  0, 0, 0, 8'h00);
        add(1, 8'hFB, 8'h00, 0, 0,  0, 0, 1, 8'h04);
        add(1, 8'hFB, 8'h00, 0, 0,  1, 2, 1, 8'h04);
        add(1, 8'hBF, 8'h00, 1, 0,  1, 2, 1, 8'h44);
        add(1, 8'hBF, 8'h04, 1, 0,  1, 2, 1, 8'h44);
        add(1, 8'hBF, 8'h00, 1, 1,  0, 0, 1, 8'h40);
        add(1, 8'hFF, 8'h00, 0, 0,  1, 6, 1, 8'h40);
        add(1, 8'hFF, 8'h00, 0, 1,  0, 0, 0, 8'h00);
        grantQ.push_back(3'd7);
        grantQ.push_back(3'd4);
        grantQ.push_back(3'd7);
        grantQ.push_back(3'd7);
        grantQ.push_back(3'd2);
        grantQ.push_back(3'd6);
`ifndef IRQ_EDGE_EN
        add(1, 8'hF7, 8'h00, 0, 0,  0, 0, 1, 8'h08);
        add(1, 8'hF7, 8'h00, 0, 0,  1, 3, 1, 8'h08);
        add(1, 8'hF7, 8'h00, 0, 1,  0, 0, 1, 8'h08);
        add(1, 8'hF7, 8'h00, 0, 0,  1, 3, 1, 8'h08);
        add(0, 8'hF7, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        add(1, 8'hFF, 8'h00, 0, 0,  0, 0, 0, 8'h00);
        grantQ.push_back(3'd3);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            runRow(vecs[i], i);
        end

`ifdef IRQ_EDGE_EN
        // Line 5 held low: one grant only.
        iRst_n = 1'b0;
        iReq_n = '1;
        iMask  = '0;
        iEI    = 1'b0;
        iAck   = 1'b0;
        tick();
        iRst_n = 1'b1;
        iReq_n = 8'hDF;
        grantQ.push_back(3'd5);
        nGrant = 0;
        for (int c = 0; c < 10; c++) begin
            iAck = oValid;
            if (oValid) nGrant++;
            tick();
        end
        iAck = 1'b0;
        chk("edge_one_grant", nGrant, 1);
        chk("edge_hold_valid", int'(oValid), 0);
        chk("edge_hold_pend", int'(oPend), 0);

        // Release and re-lower: a second grant.
        iReq_n = 8'hFF;
        tick();
        tick();
        iReq_n = 8'hDF;
        grantQ.push_back(3'd5);
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick();
            if (oValid) found = 1'b1;
        end
        chk("edge_regrant", int'(found), 1);
        iAck = 1'b1;
        tick();
        iAck = 1'b0;
        chk("edge_after_ack_valid", int'(oValid), 0);
        tick();
        chk("edge_no_repend", int'(oPend), 0);
`endif

        tick();
        chk("grant_queue_empty", grantQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
